tick_controller: RTL
====================

Name: tick_controller

Overview:
- Upstream stage of the cascaded up-counter chain.
- Turns two asynchronous push-button inputs (run/stop toggle, single step) into the one-cycle enable pulse that drives the first counter digit's carry-in.
- Provides free-running mode at a programmable prescaled rate, and a single-step mode for manual counting.

Parameters:
- DIV_WIDTH, 4, width of the prescale divisor input and the internal prescale counter.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- run_btn  input  1  asynchronous level from the run/stop button; each rising edge toggles run/stop.
- step_btn  input  1  asynchronous level from the step button; each rising edge requests one tick while stopped.
- div  input  DIV_WIDTH  prescale divisor; tick period in RUNNING is div+1 clocks.
- tick  output  1  registered one-cycle enable pulse, wired to the counter's carry-in.
- running  output  1  registered; high while in RUNNING state.

Behaviour:
- Reset (async, active-high):
  - state=STOPPED, tick=0, running=0, prescale count=0.
  - All synchroniser and edge-detect flops cleared to 0.
- Input conditioning, per button:
  - 2-flop synchroniser (s1, s2), then a history flop s3.
  - edge = s2 & ~s3.
  - Input high before clock edge k gives edge=1 during the cycle after edge k+1; the state acts on edge k+2.
  - A button held high through reset release produces exactly one edge after reset (flops reset to 0).
  - A held button yields one edge only; the next edge needs a low level for at least 2 clocks.
- FSM states: STOPPED, STEP, RUNNING.
- STOPPED:
  - run edge -> RUNNING; prescale count cleared to 0.
  - Otherwise step edge -> STEP.
  - Otherwise stay in STOPPED.
  - tick=0.
- STEP (exactly one cycle):
  - tick=1.
  - Next state RUNNING if a run edge is present this cycle (prescale count cleared to 0), else STOPPED.
  - Step edges in this cycle are dropped.
- RUNNING:
  - Each cycle: if count >= div, then tick_next=1 and count<=0; else count<=count+1 and tick_next=0.
  - run edge -> STOPPED; tick_next=0 and count is held.
  - Step edges are ignored.
- Tick timing:
  - First tick is high div+1 clocks after running rises; steady period is div+1.
  - div=0 gives tick high every cycle while RUNNING.
  - count and div are unsigned DIV_WIDTH; count never exceeds the maximum div value, so no wrap.
- div changed mid-count:
  - Takes effect immediately.
  - If count >= new div, a tick fires on the next edge and the count restarts at 0.
- Simultaneous run and step edges in STOPPED: run wins; step is discarded.
- running is a registered decode of state == RUNNING, updated on the same edge as the state.
- tick is never high in STOPPED.
- Reset asserted mid-tick forces tick=0 immediately (asynchronously).

Decomposition:
- Shared package: state encodings TC_STOPPED=2'd0, TC_STEP=2'd1, TC_RUNNING=2'd2; DIV_WIDTH default.
- Sub-module: sync_edge_detector (3 flops, async active-high reset, outputs edge). Instantiated twice, once for run_btn and once for step_btn.

Test Plan:
- Reset release with both buttons low, div=3: tick=0 and running=0 for 20 cycles.
- run_btn pulsed high for 4 cycles, div=3 -> running rises 3 edges after first sample; tick then high 1 cycle at 4, 8, 12 clocks after running rises.
- From STOPPED, step_btn pulsed 3 times with ≥4 low cycles between -> exactly 3 single-cycle ticks, each 3 edges after its press; running stays 0.
- div=0 in RUNNING -> tick high every cycle. A second run_btn press -> running falls and tick is 0 from the same edge; count held.
- RUNNING with div=7 and count=5, div changed to 2 -> tick on the next edge, then every 3 clocks.
- run_btn and step_btn rising in the same cycle while STOPPED -> RUNNING entered, no step tick. Separately, run_btn held high through reset release -> exactly one toggle to RUNNING.

Source files
------------

// File: rtl/tick_controller_pkg.sv
// Shared definitions for the tick controller: FSM state encoding and default widths.
package tick_controller_pkg;

    localparam int unsigned DIV_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        TC_STOPPED = 2'd0,
        TC_STEP    = 2'd1,
        TC_RUNNING = 2'd2
    } tc_state_e;

endpackage

// File: rtl/sync_edge_detector.sv
// Two-flop synchroniser for an asynchronous button level, followed by a rising-edge detector.
module sync_edge_detector (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic s1, s2, s3;

    // Cleared flops make a button held through reset release look like a fresh press.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/tick_controller.sv
// Generates the carry-in enable pulse for the counter chain, either free-running at a
// prescaled rate or one pulse per step-button press.
module tick_controller
    import tick_controller_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 run_btn,
    input  logic                 step_btn,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick,
    output logic                 running
);

    logic run_rise;
    logic step_rise;

    sync_edge_detector u_run_sync (
        .clock (clock),
        .reset (reset),
        .btn   (run_btn),
        .rise  (run_rise)
    );

    sync_edge_detector u_step_sync (
        .clock (clock),
        .reset (reset),
        .btn   (step_btn),
        .rise  (step_rise)
    );

    tc_state_e            state_q, state_d;
    logic [DIV_WIDTH-1:0] count_q, count_d;
    logic                 tick_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tick_d  = 1'b0;
        unique case (state_q)
            TC_STOPPED: begin
                // Run has priority; a simultaneous step press is discarded.
                if (run_rise) begin
                    state_d = TC_RUNNING;
                    count_d = '0;
                end else if (step_rise) begin
                    state_d = TC_STEP;
                    tick_d  = 1'b1;
                end
            end
            TC_STEP: begin
                if (run_rise) begin
                    state_d = TC_RUNNING;
                    count_d = '0;
                end else begin
                    state_d = TC_STOPPED;
                end
            end
            TC_RUNNING: begin
                if (run_rise) begin
                    state_d = TC_STOPPED;
                end else if (count_q >= div) begin
                    // >= so a divisor lowered below the current count fires right away.
                    tick_d  = 1'b1;
                    count_d = '0;
                end else begin
                    count_d = count_q + DIV_WIDTH'(1);
                end
            end
            default: begin
                state_d = TC_STOPPED;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= TC_STOPPED;
            count_q <= '0;
            tick    <= 1'b0;
            running <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tick    <= tick_d;
            running <= (state_d == TC_RUNNING);
        end
    end

endmodule
